// File: rtl/rv32_pkg.sv
// rv32_pkg -- constants and types shared by the RV32IM ID/EX stage.
//
// Contents:
//   XLEN, SEL_W, RA_W         datapath / ALU-select / register-index widths
//   ALU_ADD, ALU_SUB, ALU_FWD ALU select codes (5'b11xxx selects FWD)
//   OP1_RS1/OP1_PC            operand-1 source encoding
//   OP2_RS2/OP2_IMM           operand-2 source encoding
//   ex_ctrl_t, CTRL_BUBBLE    EX control bundle and its bubble value
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int SEL_W = 5;
    localparam int RA_W  = 5;

    localparam logic [SEL_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [SEL_W-1:0] ALU_SUB = 5'b10000;
    localparam logic [SEL_W-1:0] ALU_FWD = 5'b11000;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_ctrl_t;

    // A bubble carries no valid bit and no side effects.
    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux -- priority operand forward select for one source register.
//
// Ports:
//   rs_addr, rf_data                     registered source index and regfile data
//   exmem_rd_addr/_reg_write/_result     producer in MEM (highest priority)
//   memwb_rd_addr/_reg_write/_result     producer in WB
//   fwd_data                             forwarded operand
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] exmem_rd_addr,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd_addr,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);
    import rv32_pkg::*;

    always_comb begin
        fwd_data = rf_data;
        // x0 is hard-wired; never take a forwarded value for it.
        if (rs_addr != '0) begin
            if (exmem_reg_write && (exmem_rd_addr == rs_addr)) begin
                fwd_data = exmem_result;
            end else if (memwb_reg_write && (memwb_rd_addr == rs_addr)) begin
                fwd_data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the RV32IM 5-stage pipeline.
// Captures decoded operands/control, forwards from EX/MEM and MEM/WB, and
// detects load-use hazards (stalls ID and injects a one-cycle EX bubble).
//
// Ports:
//   CLK, RESET           clock (rising edge), synchronous active-high reset
//   id_*                 decoded instruction from ID
//   flush                redirect: the instruction entering EX is killed
//   exmem_*, memwb_*     downstream producers for forwarding
//   alu_data1/2, alu_select   ALU operands and opcode
//   ex_*                 registered instruction state in EX
//   stall_id             hold PC and IF/ID this cycle
//
// Optional feature (macro ID_EX_PERF_CNT_EN): adds saturating 32-bit
// counters perf_bubbles and perf_loaduse as extra outputs.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5,
    parameter int RA_W  = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1_addr,
    input  logic [RA_W-1:0]  id_rs2_addr,
    input  logic [RA_W-1:0]  id_rd_addr,
    input  logic [SEL_W-1:0] id_alu_select,
    input  logic             id_op1_sel,
    input  logic             id_op2_sel,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic [RA_W-1:0]  exmem_rd_addr,
    input  logic             exmem_reg_write,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic [RA_W-1:0]  memwb_rd_addr,
    input  logic             memwb_reg_write,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  alu_data1,
    output logic [XLEN-1:0]  alu_data2,
    output logic [SEL_W-1:0] alu_select,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RA_W-1:0]  ex_rd_addr,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]      perf_bubbles,
    output logic [31:0]      perf_loaduse,
`endif
    output logic             stall_id
);
    import rv32_pkg::*;

    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [RA_W-1:0]  rs1_addr_q, rs1_addr_d;
    logic [RA_W-1:0]  rs2_addr_q, rs2_addr_d;
    logic [RA_W-1:0]  rd_addr_q, rd_addr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             op1_sel_q, op1_sel_d;
    logic             op2_sel_q, op2_sel_d;

    logic             load_use;
    logic             bubble;
    logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

    always_comb begin
        // Conservative: any match on rs1/rs2 stalls, whether or not the
        // instruction in ID actually reads that operand.
        load_use = ctrl_q.valid && ctrl_q.mem_read && (rd_addr_q != '0) && id_valid &&
                   ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
        stall_id = load_use && !flush;
        bubble   = flush || load_use;

        ctrl_d     = CTRL_BUBBLE;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_addr_d = '0;
        rs2_addr_d = '0;
        rd_addr_d  = '0;
        sel_d      = ALU_ADD;
        op1_sel_d  = OP1_RS1;
        op2_sel_d  = OP2_RS2;
        if (!bubble) begin
            ctrl_d.valid     = id_valid;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            ctrl_d.mem_write = id_mem_write;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_addr_d  = id_rd_addr;
            sel_d      = id_alu_select;
            op1_sel_d  = id_op1_sel;
            op2_sel_d  = id_op2_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q     <= CTRL_BUBBLE;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            sel_q      <= ALU_ADD;
            op1_sel_q  <= OP1_RS1;
            op2_sel_q  <= OP2_RS2;
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            sel_q      <= sel_d;
            op1_sel_q  <= op1_sel_d;
            op2_sel_q  <= op2_sel_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr        (rs1_addr_q),
        .rf_data        (rs1_data_q),
        .exmem_rd_addr  (exmem_rd_addr),
        .exmem_reg_write(exmem_reg_write),
        .exmem_result   (exmem_result),
        .memwb_rd_addr  (memwb_rd_addr),
        .memwb_reg_write(memwb_reg_write),
        .memwb_result   (memwb_result),
        .fwd_data       (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr        (rs2_addr_q),
        .rf_data        (rs2_data_q),
        .exmem_rd_addr  (exmem_rd_addr),
        .exmem_reg_write(exmem_reg_write),
        .exmem_result   (exmem_result),
        .memwb_rd_addr  (memwb_rd_addr),
        .memwb_reg_write(memwb_reg_write),
        .memwb_result   (memwb_result),
        .fwd_data       (fwd_rs2)
    );

    assign alu_data1     = (op1_sel_q == OP1_PC)  ? pc_q  : fwd_rs1;
    assign alu_data2     = (op2_sel_q == OP2_IMM) ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_select    = sel_q;
    assign ex_valid      = ctrl_q.valid;
    assign ex_pc         = pc_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic [31:0] perf_loaduse_q, perf_loaduse_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_bubbles_d = perf_bubbles_q;
        perf_loaduse_d = perf_loaduse_q;
        if (bubble && (perf_bubbles_q != '1)) perf_bubbles_d = perf_bubbles_q + 32'd1;
        if (stall_id && (perf_loaduse_q != '1)) perf_loaduse_d = perf_loaduse_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_bubbles_q <= '0;
            perf_loaduse_q <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_loaduse_q <= perf_loaduse_d;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_loaduse = perf_loaduse_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- self-checking bench for id_ex_stage: directed scenarios
// followed by randomized traffic, all compared against a behavioural model
// of the instruction held in EX.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [4:0]  id_alu_select;
    logic        id_op1_sel, id_op2_sel;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  exmem_rd_addr;
    logic        exmem_reg_write;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd_addr;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;
    logic [31:0] alu_data1, alu_data2;
    logic [4:0]  alu_select;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        stall_id;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    id_ex_stage dut (
        .CLK(CLK), .RESET(RESET),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_select(id_alu_select), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_id(stall_id)
    );

    // Model of the instruction currently sitting in EX.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, rd, sel;
        logic        o1, o2, rw, mr, mw;
    } ex_rec_t;

    ex_rec_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return d;
        if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
        return d;
    endfunction

    function automatic logic ref_load_use();
        return m.v && m.mr && (m.rd != 5'd0) && id_valid &&
               ((m.rd == id_rs1_addr) || (m.rd == id_rs2_addr));
    endfunction

    task automatic clear_inputs();
        RESET = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_alu_select = '0; id_op1_sel = 1'b0; id_op2_sel = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0;
        exmem_rd_addr = '0; exmem_reg_write = 1'b0; exmem_result = '0;
        memwb_rd_addr = '0; memwb_reg_write = 1'b0; memwb_result = '0;
    endtask

    // Inputs are already applied (after a negedge). Check outputs, then
    // advance the model across the next rising edge.
    task automatic step();
        logic lu;
        #1;
        lu = ref_load_use();
        chk("stall_id",   32'(stall_id),     32'(lu && !flush));
        chk("ex_valid",   32'(ex_valid),     32'(m.v));
        chk("ex_pc",      ex_pc,             m.pc);
        chk("ex_rd",      32'(ex_rd_addr),   32'(m.rd));
        chk("ex_rw",      32'(ex_reg_write), 32'(m.rw));
        chk("ex_mr",      32'(ex_mem_read),  32'(m.mr));
        chk("ex_mw",      32'(ex_mem_write), 32'(m.mw));
        chk("alu_sel",    32'(alu_select),   32'(m.sel));
        chk("alu_data1",  alu_data1,  m.o1 ? m.pc  : fwd_ref(m.a1, m.r1));
        chk("alu_data2",  alu_data2,  m.o2 ? m.imm : fwd_ref(m.a2, m.r2));
        chk("store_data", ex_store_data, fwd_ref(m.a2, m.r2));
        @(posedge CLK);
        if (RESET || flush || lu) begin
            m = '0;
        end else begin
            m.v = id_valid; m.pc = id_pc; m.r1 = id_rs1_data; m.r2 = id_rs2_data;
            m.imm = id_imm; m.a1 = id_rs1_addr; m.a2 = id_rs2_addr; m.rd = id_rd_addr;
            m.sel = id_alu_select; m.o1 = id_op1_sel; m.o2 = id_op2_sel;
            m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
        end
        @(negedge CLK);
    endtask

    task automatic load_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] d1, input logic [31:0] d2, input logic mr);
        clear_inputs();
        id_valid = 1'b1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_reg_write = 1'b1; id_mem_read = mr;
        id_pc = 32'h40; id_alu_select = 5'b00000;
        step();
    endtask

    task automatic rand_inputs();
        RESET           = ($urandom_range(0, 39) == 0);
        id_valid        = ($urandom_range(0, 3) != 0);
        id_pc           = $urandom;
        id_rs1_data     = $urandom;
        id_rs2_data     = $urandom;
        id_imm          = $urandom;
        id_rs1_addr     = 5'($urandom_range(0, 3));
        id_rs2_addr     = 5'($urandom_range(0, 3));
        id_rd_addr      = 5'($urandom_range(0, 3));
        id_alu_select   = 5'($urandom_range(0, 31));
        id_op1_sel      = 1'($urandom_range(0, 1));
        id_op2_sel      = 1'($urandom_range(0, 1));
        id_reg_write    = 1'($urandom_range(0, 1));
        id_mem_read     = ($urandom_range(0, 2) == 0);
        id_mem_write    = 1'($urandom_range(0, 1));
        flush           = ($urandom_range(0, 7) == 0);
        exmem_rd_addr   = 5'($urandom_range(0, 3));
        exmem_reg_write = 1'($urandom_range(0, 1));
        exmem_result    = $urandom;
        memwb_rd_addr   = 5'($urandom_range(0, 3));
        memwb_reg_write = 1'($urandom_range(0, 1));
        memwb_result    = $urandom;
    endtask

    initial begin
        clear_inputs();
        m = '0;
        // Reset for 2 cycles with a live instruction in ID.
        RESET = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1;
        id_alu_select = 5'b11000;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_sel",   32'(alu_select), 32'd0);
        chk("rst_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
        step();

        // EX/MEM forward: ADD x3,x1,x2 with regfile 5 / 7.
        load_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
        clear_inputs();
        exmem_rd_addr = 5'd1; exmem_reg_write = 1'b1; exmem_result = 32'd100;
        #1;
        chk("fwd_exmem_d1", alu_data1, 32'd100);
        chk("fwd_exmem_d2", alu_data2, 32'd7);
        step();

        // Forward priority: both producers target x2.
        load_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
        clear_inputs();
        exmem_rd_addr = 5'd2; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
        memwb_rd_addr = 5'd2; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
        #1;
        chk("fwd_prio", alu_data2, 32'hAA);
        step();

        // x0: never forwarded even when producers name x0.
        load_instr(5'd0, 5'd0, 5'd3, 32'h11, 32'h77, 1'b0);
        clear_inputs();
        exmem_rd_addr = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
        memwb_rd_addr = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
        #1;
        chk("fwd_x0", alu_data2, 32'h77);
        step();

        // Load-use: LW x5 in EX, dependent instruction in ID.
        load_instr(5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 1'b1);
        clear_inputs();
        id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs2_addr = 5'd6; id_rd_addr = 5'd7;
        id_rs1_data = 32'hDEAD; id_reg_write = 1'b1;
        #1;
        chk("lu_stall", 32'(stall_id), 32'd1);
        step();
        chk("lu_stall_once", 32'(stall_id), 32'd0);
        chk("lu_bubble_v",   32'(ex_valid), 32'd0);
        chk("lu_bubble_rw",  32'(ex_reg_write), 32'd0);
        step();
        id_valid = 1'b0;
        memwb_rd_addr = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h1234;
        #1;
        chk("lu_dep_valid", 32'(ex_valid), 32'd1);
        chk("lu_dep_fwd",   alu_data1, 32'h1234);
        step();

        // Flush coinciding with load-use.
        load_instr(5'd1, 5'd2, 5'd5, 32'd0, 32'd0, 1'b1);
        clear_inputs();
        id_valid = 1'b1; id_rs1_addr = 5'd5; id_reg_write = 1'b1; flush = 1'b1;
        #1;
        chk("flush_lu_stall", 32'(stall_id), 32'd0);
        step();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        step();

        // PC / immediate select.
        clear_inputs();
        id_valid = 1'b1; id_op1_sel = 1'b1; id_op2_sel = 1'b1; id_pc = 32'h100;
        id_imm = 32'hFFFF_FFFC; id_rs2_addr = 5'd2; id_rs2_data = 32'h9;
        step();
        clear_inputs();
        exmem_rd_addr = 5'd2; exmem_reg_write = 1'b1; exmem_result = 32'h55;
        #1;
        chk("pc_sel",  alu_data1, 32'h100);
        chk("imm_sel", alu_data2, 32'hFFFF_FFFC);
        chk("st_fwd",  ex_store_data, 32'h55);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32IM 5-stage pipeline. It sits directly upstream of the ALU.
- Captures decoded operands and control from ID, then produces the ALU's DATA1, DATA2 and SELECT.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards: requests an ID stall and injects a one-cycle bubble into EX.

Parameters:
- XLEN, 32, datapath width.
- SEL_W, 5, ALU select width. Matches the ALU opcode map: 5'b00000 = ADD, 5'b11xxx = FWD.
- RA_W, 5, register address width.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register indices.
- id_alu_select  in  SEL_W  ALU operation code.
- id_op1_sel  in  1  0 = rs1, 1 = PC.
- id_op2_sel  in  1  0 = rs2, 1 = imm.
- id_reg_write, id_mem_read, id_mem_write  in  1  control flags.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- exmem_rd_addr  in  RA_W  destination register of the instruction in MEM.
- exmem_reg_write  in  1  write-enable of the instruction in MEM.
- exmem_result  in  XLEN  result of the instruction in MEM.
- memwb_rd_addr  in  RA_W  destination register of the instruction in WB.
- memwb_reg_write  in  1  write-enable of the instruction in WB.
- memwb_result  in  XLEN  result of the instruction in WB.
- alu_data1, alu_data2  out  XLEN  ALU operands.
- alu_select  out  SEL_W  ALU operation code.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  XLEN  PC of the instruction in EX.
- ex_store_data  out  XLEN  forwarded rs2 value, for stores.
- ex_rd_addr  out  RA_W  destination register of the instruction in EX.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control flags.
- stall_id  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Interface: one clock (CLK). Reset (RESET) is synchronous and active-high.
- Reset: all registered fields are 0 on the next edge. Consequently:
  - ex_valid = 0 and all control flags = 0.
  - alu_select = 5'b00000.
  - stall_id = 0.
- Latency: one cycle, ID to EX.
- Capture priority on each rising edge, highest first: RESET, then flush, then load-use, then normal capture.
  - flush: inject a bubble.
  - load-use: inject a bubble; ID is held by the upstream logic.
  - Otherwise: capture all id_* fields, with ex_valid = id_valid.
- Bubble: valid and all control flags = 0, data fields = 0, select = 5'b00000.
  - A bubble must never write a register or memory.
- Load-use detection (combinational) asserts when all of the following hold:
  - ex_valid & ex_mem_read;
  - ex_rd_addr != 0;
  - id_valid;
  - ex_rd_addr equals id_rs1_addr or id_rs2_addr.
  - The compare is conservative: it ignores operand use.
- stall_id = load_use & ~flush. It lasts exactly one cycle per load-use pair.
- Forwarding (combinational, from the registered rs addresses) for each of rs1 and rs2:
  - If the address is 0: use the registered value. x0 is never forwarded.
  - Else if exmem_reg_write and exmem_rd_addr match: use exmem_result. EX/MEM wins over MEM/WB.
  - Else if memwb_reg_write and memwb_rd_addr match: use memwb_result.
  - Else: use the registered register-file data.
- Operand selection:
  - alu_data1 = op1_sel ? ex_pc : fwd_rs1.
  - alu_data2 = op2_sel ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of op2_sel.
- Simultaneous events:
  - flush together with load_use: flush wins and stall_id = 0.
  - RESET asserted mid-stall clears the stall state on the same edge.
- Forwarding on bubble inputs: the stage does not qualify forwarding with downstream valid. Upstream stages must drive reg_write = 0 for bubbles.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbles (32 bit) and perf_loaduse (32 bit).
  - perf_bubbles counts cycles in which a bubble is injected by flush or load-use.
  - perf_loaduse counts cycles with stall_id = 1.
  - Both counters saturate at 0xFFFFFFFF and clear on RESET.
- Undefined: no counters and no extra ports. The rest of the behaviour is identical.

Decomposition:
- Shared package rv32_pkg:
  - XLEN and SEL_W constants.
  - ALU select localparams: ALU_ADD = 5'b00000, ALU_SUB = 5'b10000, ALU_FWD = 5'b11000.
  - OP1_RS1/OP1_PC and OP2_RS2/OP2_IMM encodings.
  - Bubble constant.
- Sub-module: fwd_mux, instantiated twice (rs1, rs2). It implements the priority forward select described above.

Test Plan:
- Reset check: RESET = 1 for 2 cycles with id_valid = 1 -> ex_valid = 0, alu_select = 0, all control flags = 0, stall_id = 0.
- EX/MEM forward: ADD x3,x1,x2 in ID (rs1 = 1, rs2 = 2, regfile data 5 and 7); exmem rd = 1, reg_write = 1, result 100 -> next cycle alu_data1 = 100, alu_data2 = 7.
- Forward priority: exmem and memwb both target x2 (results 0xAA, 0xBB) -> alu_data2 = 0xAA. Repeat with rd = 0 -> no forwarding, regfile value used.
- Load-use: LW x5 in EX (mem_read = 1), ID holds rs1 = 5 -> stall_id = 1 for exactly 1 cycle, then a bubble in EX (ex_valid = 0, reg_write = 0). One cycle later the dependent instruction is in EX with memwb_result forwarded.
- Flush with load-use: flush = 1 in the same cycle as load_use -> stall_id = 0 and a bubble is captured.
- Immediate/PC select: op1_sel = 1, op2_sel = 1, pc = 0x100, imm = 0xFFFFFFFC -> alu_data1 = 0x100, alu_data2 = 0xFFFFFFFC, ex_store_data = forwarded rs2.
